// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive path
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam int DATA_BITS = 8;

   // Clocks per oversample tick; never below 1 so the divider always advances.
   function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
      int d;
      d = clk_freq / (baud_rate * oversample);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte holding register handshake and status bundle
interface uart_rx_if;

   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      output data_out, data_valid, frame_err, overrun, busy,
      input  data_ready
   );

   modport slave (
      input  data_out, data_valid, frame_err, overrun, busy,
      output data_ready
   );

endinterface

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - oversampling tick divider, restartable via clear
module uart_os_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic os_tick
);

   localparam logic [15:0] TOP = 16'(DIV - 1);

   logic [15:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || cnt == TOP) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

   assign os_tick = (cnt == TOP);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and a valid/ready holding register
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   uart_rx_if.master  bus
);

   localparam int             DIV         = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int             SW          = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0]  MID_START   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0]  LAST_SAMPLE = SW'(OVERSAMPLE - 1);
   localparam logic [2:0]     LAST_BIT    = 3'(DATA_BITS - 1);

   state_t        state;
   logic          rx_meta, rx_s, rx_prev;
   logic [SW-1:0] sample_cnt, sample_next;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          os_tick, tick_clear;
   logic [7:0]    data_q;
   logic          valid_q, fe_q, ov_q;

   // Holding the divider in clear while idle restarts its phase at the start edge.
   assign tick_clear  = (state == IDLE);
   assign sample_next = (sample_cnt == LAST_SAMPLE) ? '0 : sample_cnt + 1'b1;

   uart_os_tick #(.DIV(DIV)) u_os_tick (
      .clk     (clk),
      .reset   (reset),
      .clear   (tick_clear),
      .os_tick (os_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sample_cnt <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         fe_q       <= 1'b0;
         ov_q       <= 1'b0;
      end else begin
         fe_q <= 1'b0;
         ov_q <= 1'b0;
         if (valid_q && bus.data_ready) begin
            valid_q <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (rx_prev && !rx_s) begin
                  sample_cnt <= '0;
                  state      <= START;
               end
            end
            START: begin
               if (os_tick) begin
                  if (sample_cnt == MID_START) begin
                     sample_cnt <= '0;
                     bit_idx    <= '0;
                     state      <= rx_s ? IDLE : DATA;
                  end else begin
                     sample_cnt <= sample_next;
                  end
               end
            end
            DATA: begin
               if (os_tick) begin
                  sample_cnt <= sample_next;
                  if (sample_cnt == LAST_SAMPLE) begin
                     shift   <= {rx_s, shift[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                     if (bit_idx == LAST_BIT) begin
                        state <= STOP;
                     end
                  end
               end
            end
            STOP: begin
               if (os_tick) begin
                  sample_cnt <= sample_next;
                  if (sample_cnt == LAST_SAMPLE) begin
                     state <= IDLE;
                     if (!rx_s) begin
                        fe_q <= 1'b1;
                     end else if (!valid_q || bus.data_ready) begin
                        data_q  <= shift;
                        valid_q <= 1'b1;
                     end else begin
                        ov_q <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.frame_err  = fe_q;
   assign bus.overrun    = ov_q;
   assign bus.busy       = (state != IDLE);

endmodule
